multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore FSM that sequences the shared multicycle MIPS datapath (single memory, one ALU, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and writeback.
- Supported instructions: R-type, lw, sw, beq, ori, j.
- Stalls in memory states until memory handshakes ready; counts retired instructions; flags illegal opcodes.
- Sits between the IR opcode field and the datapath mux/enable controls.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- RESET_PC_HOLD, 1, cycles spent in IDLE after reset release before the first FETCH (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write  out  1 each  datapath enables and address select.
- reg_dst, reg_write, mem_to_reg, alu_src_a, ext_zero, r_type  out  1 each  register-file, ALU-A and extender controls; r_type selects funct decode.
- alu_src_b  out  2  00 B, 01 const 4, 10 ext(imm), 11 sext(imm)<<2.
- alu_op  out  3  000 add, 100 sub, 110 or; ignored when r_type=1.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- instr_count  out  CNT_W  retired instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: rst_n low → state=IDLE immediately, hold counter=0, instr_count=0. All outputs are 0 in IDLE.
- IDLE: stays RESET_PC_HOLD cycles, then goes to FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target to ALUOut). Next state by op:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 001101 → ORI_EXEC
  - 000010 → JUMP
  - else → FETCH with illegal_op=1 for this cycle; not counted as retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_zero=0, alu_op=000. Goes to MEM_RD if op[3]=0, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Stay while !mem_ready; then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire; go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1 held every cycle until mem_ready. Retire on the mem_ready cycle; go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, r_type=1. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire; go to FETCH.
- ORI_EXEC: alu_src_a=1, alu_src_b=10, ext_zero=1, alu_op=110. Go to ORI_WB.
- ORI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire; go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_write_cond=1, pc_source=01. Retire regardless of zero; go to FETCH.
- JUMP: pc_write=1, pc_source=10. Retire; go to FETCH.
- Retire means instr_count+1, wrapping modulo 2^CNT_W (all-ones → 0).
- Any signal not listed for a state is 0 in that state.
- Outputs are purely a function of state (and mem_ready, for ir_write/pc_write); no output registers.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset asserted mid-stall or mid-instruction aborts immediately to IDLE; no partial writes occur after the reset edge.
- Undefined state encodings go to IDLE.
- CPI: R/ori 4, lw 5, sw 4, beq/j 3, each plus stall cycles.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_J;
  - the state enum (4-bit);
  - ALU_ADD/SUB/OR codes;
  - SRCB_* and PCSRC_* encodings.
- Single module, no sub-module. Next-state logic and output decode are separate always blocks in the same file.

Test Plan:
- Reset then release with mem_ready=1 → IDLE for 1 cycle, FETCH with mem_read=1 and ir_write=1, outputs 0 during reset.
- op=100011, mem_ready=1 always → state sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; instr_count 0→1 after MEM_WB; reg_write and mem_to_reg=1 in MEM_WB only.
- op=101011, mem_ready low for 3 cycles in MEM_WR → mem_write held 4 cycles, no retire until the ready cycle, then FETCH.
- op=000100 with zero=1, then with zero=0 → pc_write_cond=1, alu_op=100 in BRANCH; both retire, count +2.
- op=111111 → illegal_op pulses for 1 cycle in DECODE, returns to FETCH, instr_count unchanged.
- Preload instr_count to all-ones (force) then run op=001101 → count wraps to 0; assert rst_n low mid-MEM_RD stall → state_dbg=IDLE immediately and mem_read=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states,
// ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_ORI_EXEC = 4'd9,
    S_ORI_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b110;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_EXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared multicycle MIPS datapath; outputs decode
// straight from state (plus mem_ready for the fetch write enables).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic             ext_zero,
  output logic             r_type,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_t           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             op_legal;

  // zero only matters to the datapath via pc_write_cond; the FSM path is fixed.
  logic unused_zero;
  assign unused_zero = zero;

  assign op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ORI) || (op == OP_J);

  always_comb begin
    state_d = S_IDLE;
    hold_d  = 4'd0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_q == HOLD_LAST) state_d = S_FETCH;
        else begin
          state_d = S_IDLE;
          hold_d  = hold_q + 4'd1;
        end
      end
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_R_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ORI:        state_d = S_ORI_EXEC;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = op[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_MEM_WR:   begin
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
        retire  = mem_ready;
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_R_WB:     begin state_d = S_FETCH; retire = 1'b1; end
      S_ORI_EXEC: state_d = S_ORI_WB;
      S_ORI_WB:   begin state_d = S_FETCH; retire = 1'b1; end
      S_BRANCH:   begin state_d = S_FETCH; retire = 1'b1; end
      S_JUMP:     begin state_d = S_FETCH; retire = 1'b1; end
      default:    state_d = S_IDLE;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    ext_zero      = 1'b0;
    r_type        = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_SEXT_SH;
        illegal_op = !op_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        r_type    = 1'b1;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ORI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_EXT;
        ext_zero  = 1'b1;
        alu_op    = ALU_OR;
      end
      S_ORI_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign instr_count = cnt_q;
  assign state_dbg   = state_q;

endmodule
